fp_lat_issue_queue: RTL

FP_LAT_ISSUE_QUEUE -- requirements
Module: fp_lat_issue_queue

---
 rtl/fp_lat_issue_queue.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_lat_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : fp_lat_issue_queue
// Description : Floating-point issue queue with per-source wakeup,
//               age-matrix oldest-first select, writeback-bus reservation
//               by FU latency, and robIdx-based redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_lat_issue_queue #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 8,
    parameter int SRC_NUM    = 3,
    parameter int WAKEUP_NUM = 4,
    parameter int PREG_W     = 7,
    parameter int ROB_W      = 7,
    parameter int MAX_LAT    = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enq_valid,
    output logic                              enq_ready,
    input  logic [DATA_W-1:0]                 enq_data,
    input  logic [ROB_W-1:0]                  enq_robIdx,
    input  logic [$clog2(MAX_LAT+1)-1:0]      enq_lat,
    input  logic [SRC_NUM*PREG_W-1:0]         enq_src,
    input  logic [SRC_NUM-1:0]                enq_src_rdy,
    input  logic [WAKEUP_NUM-1:0]             wakeup_valid,
    input  logic [WAKEUP_NUM*PREG_W-1:0]      wakeup_preg,
    input  logic                              issue_ready,
    output logic                              issue_valid,
    output logic [DATA_W-1:0]                 issue_data,
    output logic [ROB_W-1:0]                  issue_robIdx,
    output logic [SRC_NUM*PREG_W-1:0]         issue_src,
    output logic [$clog2(MAX_LAT+1)-1:0]      issue_lat,
    input  logic                              redirect,
    input  logic [ROB_W-1:0]                  redirect_idx,
    output logic                              full,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int LW = $clog2(MAX_LAT+1);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    localparam int RW = MAX_LAT + 2;

    // True when any valid wakeup port broadcasts the given tag.
    function automatic logic wake_hit(input logic [PREG_W-1:0]            tag,
                                      input logic [WAKEUP_NUM-1:0]        vld,
                                      input logic [WAKEUP_NUM*PREG_W-1:0] pregs);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WAKEUP_NUM; k++) begin
            if (vld[k] && (pregs[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Loop-order comparison: idx comes after redir in program order.
    function automatic logic is_younger(input logic [ROB_W-1:0] idx,
                                        input logic [ROB_W-1:0] redir);
        if (idx[ROB_W-1] != redir[ROB_W-1])
            return idx[ROB_W-2:0] < redir[ROB_W-2:0];
        else
            return idx[ROB_W-2:0] > redir[ROB_W-2:0];
    endfunction

    // Entry storage
    logic [DEPTH-1:0]          r_valid;
    logic [DATA_W-1:0]         r_data  [DEPTH];
    logic [ROB_W-1:0]          r_rob   [DEPTH];
    logic [LW-1:0]             r_lat   [DEPTH];
    logic [SRC_NUM*PREG_W-1:0] r_src   [DEPTH];
    logic [SRC_NUM-1:0]        r_rdy   [DEPTH];
    // r_older[i][j] = 1 : entry j is older than entry i
    logic [DEPTH-1:0]          r_older [DEPTH];

    // Writeback reservation: bit j set means the result bus is busy j cycles ahead
    logic [RW-1:0]             r_resv;
    logic [CW-1:0]             r_count;

    logic                      r_issue_valid;
    logic [DATA_W-1:0]         r_issue_data;
    logic [ROB_W-1:0]          r_issue_rob;
    logic [SRC_NUM*PREG_W-1:0] r_issue_src;
    logic [LW-1:0]             r_issue_lat;

    logic                      w_enq_fire;
    logic [DEPTH-1:0]          w_enq_oh;
    logic [SRC_NUM-1:0]        w_enq_rdy;
    logic [DEPTH-1:0]          w_flush;
    logic [DEPTH-1:0]          w_elig;
    logic [DEPTH-1:0]          w_sel_oh;
    logic                      w_sel;
    logic [IW-1:0]             w_sel_idx;
    logic [DEPTH-1:0]          w_valid_nxt;
    logic [CW-1:0]             w_count_nxt;
    logic [RW-1:0]             w_resv_nxt;

    assign full       = (r_count == CW'(DEPTH));
    assign count      = r_count;
    assign enq_ready  = ~full & ~redirect;
    assign w_enq_fire = enq_valid & enq_ready;

    // Pick the lowest-index entry that is free at the start of the cycle.
    always_comb begin
        logic found;
        found    = 1'b0;
        w_enq_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_valid[i] && !found) begin
                found       = 1'b1;
                w_enq_oh[i] = 1'b1;
            end
        end
    end

    // Incoming source readiness, including same-cycle wakeups.
    always_comb begin
        w_enq_rdy = '0;
        for (int s = 0; s < SRC_NUM; s++) begin
            w_enq_rdy[s] = enq_src_rdy[s] |
                           wake_hit(enq_src[s*PREG_W +: PREG_W], wakeup_valid, wakeup_preg);
        end
    end

    // Flush mask, eligibility and oldest-first selection.
    always_comb begin
        logic busy;
        busy      = 1'b0;
        w_flush   = '0;
        w_elig    = '0;
        w_sel_oh  = '0;
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_flush[i] = redirect & r_valid[i] & is_younger(r_rob[i], redirect_idx);
            // Result would land lat+1 cycles from now: check bit lat of R>>1.
            busy       = |((r_resv >> 1) & (RW'(1) << r_lat[i]));
            w_elig[i]  = issue_ready & r_valid[i] & ~w_flush[i] & (&r_rdy[i]) & ~busy;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_sel_oh[i] = w_elig[i] & ~(|(w_elig & r_older[i]));
            if (w_sel_oh[i]) w_sel_idx = IW'(i);
        end
        w_sel = |w_sel_oh;
    end

    // Next valid vector, occupancy and reservation shift.
    always_comb begin
        w_valid_nxt = (r_valid & ~w_sel_oh & ~w_flush) | (w_enq_fire ? w_enq_oh : '0);
        w_count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_nxt = w_count_nxt + CW'(w_valid_nxt[i]);
        end
        w_resv_nxt = (r_resv >> 1) | (w_sel ? (RW'(1) << r_lat[w_sel_idx]) : '0);
    end

    // Entry state: allocation, wakeup, and age-matrix maintenance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
                r_rdy[i]   <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                for (int s = 0; s < SRC_NUM; s++) begin
                    if (wake_hit(r_src[i][s*PREG_W +: PREG_W], wakeup_valid, wakeup_preg))
                        r_rdy[i][s] <= 1'b1;
                end
                for (int j = 0; j < DEPTH; j++) begin
                    if (w_sel_oh[j] | w_flush[j] | (w_enq_fire & w_enq_oh[j]))
                        r_older[i][j] <= 1'b0;
                end
                if (w_enq_fire && w_enq_oh[i]) begin
                    r_data[i]  <= enq_data;
                    r_rob[i]   <= enq_robIdx;
                    r_lat[i]   <= enq_lat;
                    r_src[i]   <= enq_src;
                    r_rdy[i]   <= w_enq_rdy;
                    // Everything still resident after this cycle is older.
                    r_older[i] <= r_valid & ~w_sel_oh & ~w_flush;
                end
            end
        end
    end

    // Issue register, reservation vector and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_issue_valid <= 1'b0;
            r_resv        <= '0;
            r_count       <= '0;
        end else begin
            r_resv        <= w_resv_nxt;
            r_count       <= w_count_nxt;
            r_issue_valid <= w_sel & ~(redirect & is_younger(r_rob[w_sel_idx], redirect_idx));
            if (w_sel) begin
                r_issue_data <= r_data[w_sel_idx];
                r_issue_rob  <= r_rob[w_sel_idx];
                r_issue_src  <= r_src[w_sel_idx];
                r_issue_lat  <= r_lat[w_sel_idx];
            end
        end
    end

    // A redirect arriving in the issue cycle still kills a younger op.
    assign issue_valid  = r_issue_valid & ~(redirect & is_younger(r_issue_rob, redirect_idx));
    assign issue_data   = r_issue_data;
    assign issue_robIdx = r_issue_rob;
    assign issue_src    = r_issue_src;
    assign issue_lat    = r_issue_lat;

endmodule
`default_nettype wire
